// File: rtl/aes_pipe_ctrl.sv
// aes_pipe_ctrl: two-requester front end for an unrolled AES-128 core.
// Optional issue/stall counters are built when AES_PIPE_CTRL_STATS_EN is defined.
module aes_pipe_ctrl #(
  parameter int LATENCY    = 10,
  parameter int OBUF_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic [127:0] c_datain,
  output logic [127:0] c_key,
  input  logic [127:0] c_dataout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  input  logic         drain_req,
  output logic         drained,
`ifdef AES_PIPE_CTRL_STATS_EN
  output logic [15:0]  issue_cnt,
  output logic [15:0]  stall_cnt,
`endif
  output logic         busy
);

  localparam int AW = $clog2(OBUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIM = (CW+1)'(OBUF_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nx;
  logic               r_last;
  logic               r_iss_v;
  logic               r_iss_id;
  logic [LATENCY-1:0] r_sr_v;
  logic [LATENCY-1:0] r_sr_id;
  logic [CW-1:0]      r_inflight;
  logic [CW-1:0]      r_count;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [127:0]       r_mem_data [OBUF_DEPTH];
  logic [OBUF_DEPTH-1:0] r_mem_id;

  logic        w_sum_ok;
  logic [CW:0] w_sum;
  logic        w_can;
  logic        w_pick1;
  logic        w_xfer;
  logic        w_wr;
  logic        w_pop;
  logic        w_empty;

  // Credits count blocks in the cipher plus blocks parked in the obuf,
  // so a write can never find the obuf full.
  assign w_sum    = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_sum_ok = (w_sum < LIM);
  assign w_can    = !rst && (r_state != S_DRAIN) && w_sum_ok;

  assign w_pick1    = req1_valid && (!req0_valid || !r_last);
  assign req0_ready = w_can && req0_valid && !w_pick1;
  assign req1_ready = w_can && w_pick1;
  assign w_xfer     = req0_ready || req1_ready;

  assign w_wr      = r_sr_v[LATENCY-1];
  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_data  = r_mem_data[r_rd_ptr];
  assign rsp_id    = r_mem_id[r_rd_ptr];

  assign w_empty = (r_inflight == '0) && (r_count == '0);
  assign busy    = !w_empty;
  assign drained = (r_state == S_DRAIN) && w_empty;

  always_comb begin
    w_state_nx = r_state;
    if (drain_req) begin
      w_state_nx = S_DRAIN;
    end else begin
      case (r_state)
        S_IDLE:   if (w_xfer) w_state_nx = S_ACTIVE;
        S_ACTIVE: if (w_empty && !w_xfer) w_state_nx = S_IDLE;
        S_DRAIN:  if (w_empty) w_state_nx = S_IDLE;
        default:  w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      c_datain   <= '0;
      c_key      <= '0;
      r_iss_v    <= 1'b0;
      r_iss_id   <= 1'b0;
      r_sr_v     <= '0;
      r_sr_id    <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_xfer) begin
        r_last   <= req1_ready;
        c_datain <= req1_ready ? req1_data : req0_data;
        c_key    <= req1_ready ? req1_key : req0_key;
      end
      // Issue flag marks the cycle the block sits on c_datain.
      r_iss_v    <= w_xfer;
      r_iss_id   <= req1_ready;
      r_sr_v     <= {r_sr_v[LATENCY-2:0], r_iss_v};
      r_sr_id    <= {r_sr_id[LATENCY-2:0], r_iss_id};
      r_inflight <= r_inflight + CW'(w_xfer) - CW'(w_wr);
      r_count    <= r_count + CW'(w_wr) - CW'(w_pop);
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_data[r_wr_ptr] <= c_dataout;
      r_mem_id[r_wr_ptr]   <= r_sr_id[LATENCY-1];
    end
  end

`ifdef AES_PIPE_CTRL_STATS_EN
  logic [15:0] r_issue_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_xfer) r_issue_cnt <= r_issue_cnt + 16'd1;
      if ((req0_valid || req1_valid) && !w_xfer)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign issue_cnt = r_issue_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
